// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a strobe/ready handshake with configurable response latency.
// Misaligned accesses complete without writing and raise a sticky error flag.
module data_mem_responder #(
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_a,
  input  logic [31:0] m_din,
  output logic [31:0] m_dout,
  input  logic        m_strobe,
  input  logic [3:0]  m_wen,
  input  logic [1:0]  m_size,
  input  logic        m_rw,
  output logic        m_ready,
  output logic        err
);

  localparam int unsigned EffLat = (LATENCY < 1) ? 1 : LATENCY;
  localparam int unsigned CntW   = (EffLat < 2) ? 1 : $clog2(EffLat);
  localparam logic [CntW-1:0] CntLoad = CntW'(EffLat - 1);
  localparam bit Direct = (EffLat == 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [AW-1:0]   r_idx;
  logic [1:0]      r_alo;
  logic [31:0]     r_din;
  logic [3:0]      r_wen;
  logic [1:0]      r_size;
  logic            r_rw;
  logic [31:0]     r_dout;
  logic            r_ready;
  logic            r_err;
  logic [31:0]     r_mem [0:(1<<AW)-1];

  logic [AW-1:0] w_idx_in;
  logic [AW-1:0] w_rd_idx;
  logic          w_misaligned;
  logic          w_accept;
  logic          w_enter_resp;
  logic          w_commit;
  logic          w_unused_addr;

  assign w_idx_in      = m_a[AW+1:2];
  assign w_unused_addr = ^m_a[31:AW+2];
  assign w_accept      = (r_state == StIdle) && m_strobe;

  // With LATENCY<=1 the read happens on the accept edge, before the address is latched.
  assign w_rd_idx = (r_state == StIdle) ? w_idx_in : r_idx;

  assign w_misaligned = (r_size == 2'd1) ? r_alo[0] :
                        (r_size[1] && (r_alo != 2'b00));

  assign w_enter_resp = (w_accept && Direct) ||
                        ((r_state == StWait) && m_strobe && (r_cnt == CntW'(1)));

  assign w_commit = !rst && (r_state == StResp) && r_rw && !w_misaligned;

  // Memory array and its output register; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wen[b]) r_mem[r_idx][8*b +: 8] <= r_din[8*b +: 8];
      end
    end
    if (rst) begin
      r_dout <= 32'd0;
    end else if (w_enter_resp) begin
      r_dout <= r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_idx  <= w_idx_in;
      r_alo  <= m_a[1:0];
      r_din  <= m_din;
      r_wen  <= m_wen;
      r_size <= m_size;
      r_rw   <= m_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (m_strobe) begin
            r_cnt <= CntLoad;
            if (Direct) begin
              r_state <= StResp;
              r_ready <= 1'b1;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (!m_strobe) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CntW'(1)) begin
              r_state <= StResp;
              r_ready <= 1'b1;
            end
          end
        end
        StResp: begin
          r_state <= StIdle;
          if (w_misaligned) r_err <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign m_dout  = r_dout;
  assign m_ready = r_ready;
  assign err     = r_err;

endmodule
